// File: rtl/instruction_ram_loader_pkg.sv
// instruction_ram_loader_pkg
// Shared constants and types for the instruction RAM and its boot-time loader.
//   INSTR_WIDTH      : width of one instruction word
//   INSTR_ADDR_WIDTH : instruction RAM address width (also the fetch address width)
//   INSTR_DEPTH      : number of words in the instruction RAM
//   loader_state_t   : loader FSM states
package instruction_ram_loader_pkg;

    localparam int INSTR_WIDTH      = 32;
    localparam int INSTR_ADDR_WIDTH = 10;
    localparam int INSTR_DEPTH      = 125;

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/instruction_ram_loader_if.sv
// instruction_ram_loader_if
// Bundles the incoming byte stream and the instruction RAM write port.
//   byteIn/byteValid/byteReady : valid/ready byte stream into the loader
//   wrEnable/wrAddress/wrData  : single-cycle RAM write strobe with address and data
// Modports:
//   master : the stream source / RAM side (drives bytes, observes writes)
//   slave  : the loader (accepts bytes, issues writes)
interface instruction_ram_loader_if
    import instruction_ram_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = INSTR_ADDR_WIDTH
) ();

    logic [7:0]             byteIn;
    logic                   byteValid;
    logic                   byteReady;
    logic                   wrEnable;
    logic [ADDR_WIDTH-1:0]  wrAddress;
    logic [INSTR_WIDTH-1:0] wrData;

    modport master (
        output byteIn, byteValid,
        input  byteReady, wrEnable, wrAddress, wrData
    );

    modport slave (
        input  byteIn, byteValid,
        output byteReady, wrEnable, wrAddress, wrData
    );

endinterface

// File: rtl/instruction_ram_loader_byte_word_packer.sv
// byte_word_packer
// Shifts four bytes (first byte most significant) into a 32-bit word.
//   clock, resetN  : clock and asynchronous active-low reset
//   clear          : restart packing at byte index 0
//   byte_en        : byte_in is consumed this cycle
//   byte_in        : stream byte
//   word           : the assembled word, valid when word_complete is 1
//   word_complete  : the byte consumed this cycle is the 4th of a word
module byte_word_packer
    import instruction_ram_loader_pkg::*;
(
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   clear,
    input  logic                   byte_en,
    input  logic [7:0]             byte_in,
    output logic [INSTR_WIDTH-1:0] word,
    output logic                   word_complete
);

    logic [1:0]             index;
    logic [INSTR_WIDTH-9:0] shift;

    // Holds the first three bytes of the word; the fourth comes straight
    // from byte_in so the word is available in the cycle it completes.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            index <= 2'd0;
            shift <= '0;
        end else if (clear) begin
            index <= 2'd0;
            shift <= '0;
        end else if (byte_en) begin
            index <= index + 2'd1;
            shift <= {shift[INSTR_WIDTH-17:0], byte_in};
        end
    end

    assign word_complete = byte_en && (index == 2'd3);
    assign word          = {shift, byte_in};

endmodule

// File: rtl/instruction_ram_loader.sv
// instruction_ram_loader
// Boot-time writer for the instruction RAM. Receives a 16-bit big-endian word
// count, then big-endian 32-bit words, writes them to addresses 0..count-1 and
// holds the CPU in stall until the image is complete.
//   clock, resetN : clock and asynchronous active-low reset
//   start         : pulse that begins a load (ignored while loading)
//   bus           : byte stream in, instruction RAM write port out (slave side)
//   cpuHold       : CPU stall request, released only when the load is done
//   done          : image loaded successfully (sticky until next start)
//   error         : load aborted (sticky until next start)
// Build option LOADER_CHECKSUM_EN: a trailing byte must equal the modulo-256
// sum of all data bytes, otherwise the load ends in ERROR.
module instruction_ram_loader
    import instruction_ram_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = INSTR_ADDR_WIDTH,
    parameter int DEPTH      = INSTR_DEPTH
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic                     start,
    instruction_ram_loader_if.slave  bus,
    output logic                     cpuHold,
    output logic                     done,
    output logic                     error
);

    loader_state_t          state;
    loader_state_t          state_next;
    logic [15:0]            count;
    logic [15:0]            count_full;
    logic [15:0]            word_cnt;
    logic [ADDR_WIDTH-1:0]  wr_address;
    logic [INSTR_WIDTH-1:0] wr_data;
    logic                   wr_enable;
    logic                   byte_ready;
    logic                   accept;
    logic                   load_start;
    logic                   data_byte;
    logic                   is_last;
    logic [INSTR_WIDTH-1:0] word;
    logic                   word_complete;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]             sum;
`else
    logic                   last_write;
`endif

    // Ready depends on state alone, so the stream is never throttled mid-image.
    assign byte_ready = (state == CNT_HI) || (state == CNT_LO) ||
                        (state == DATA)   || (state == CHECK);
    assign accept     = bus.byteValid && byte_ready;
    assign load_start = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign data_byte  = accept && (state == DATA);
    assign count_full = {count[15:8], bus.byteIn};
    assign is_last    = (word_cnt == count - 16'd1);

    byte_word_packer u_packer (
        .clock         (clock),
        .resetN        (resetN),
        .clear         (load_start),
        .byte_en       (data_byte),
        .byte_in       (bus.byteIn),
        .word          (word),
        .word_complete (word_complete)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Without the checksum the last write pulse itself moves DATA to DONE,
    // which places done one cycle after that pulse. With the checksum the
    // 4th byte of the last word moves straight to CHECK so an immediately
    // following checksum byte lands in CHECK, not DATA.
    always_comb begin
        state_next = state;
        cpuHold    = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = CNT_HI;
            end
            CNT_HI: begin
                if (accept) state_next = CNT_LO;
            end
            CNT_LO: begin
                if (accept) begin
                    if ((count_full == 16'd0) || (count_full > 16'(DEPTH))) state_next = ERROR;
                    else                                                    state_next = DATA;
                end
            end
            DATA: begin
`ifdef LOADER_CHECKSUM_EN
                if (word_complete && is_last) state_next = CHECK;
`else
                if (last_write) state_next = DONE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept) state_next = (bus.byteIn == sum) ? DONE : ERROR;
            end
`endif
            DONE: begin
                done    = 1'b1;
                cpuHold = 1'b0;
                if (start) state_next = CNT_HI;
            end
            ERROR: begin
                error = 1'b1;
                if (start) state_next = CNT_HI;
            end
            default: state_next = IDLE;
        endcase
    end

    // Count capture, word counter, RAM write port and checksum. The write
    // address comes from the word counter, so it equals the word's index and
    // holds after the pulse until the next write.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count      <= 16'd0;
            word_cnt   <= 16'd0;
            wr_address <= '0;
            wr_data    <= '0;
            wr_enable  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum        <= 8'd0;
`else
            last_write <= 1'b0;
`endif
        end else begin
            wr_enable  <= 1'b0;
`ifndef LOADER_CHECKSUM_EN
            last_write <= 1'b0;
`endif
            if (load_start) begin
                count      <= 16'd0;
                word_cnt   <= 16'd0;
                wr_address <= '0;
`ifdef LOADER_CHECKSUM_EN
                sum        <= 8'd0;
`endif
            end else begin
                if (accept && (state == CNT_HI)) count[15:8] <= bus.byteIn;
                if (accept && (state == CNT_LO)) count[7:0]  <= bus.byteIn;
`ifdef LOADER_CHECKSUM_EN
                if (data_byte) sum <= sum + bus.byteIn;
`endif
                if (word_complete) begin
                    wr_enable  <= 1'b1;
                    wr_data    <= word;
                    wr_address <= word_cnt[ADDR_WIDTH-1:0];
                    word_cnt   <= word_cnt + 16'd1;
`ifndef LOADER_CHECKSUM_EN
                    last_write <= is_last;
`endif
                end
            end
        end
    end

    assign bus.byteReady = byte_ready;
    assign bus.wrEnable  = wr_enable;
    assign bus.wrAddress = wr_address;
    assign bus.wrData    = wr_data;

endmodule

// File: tb/tb_instruction_ram_loader.sv
// tb_instruction_ram_loader
// Self-checking bench for instruction_ram_loader. Stimulus tasks push the
// expected RAM writes into a queue; a monitor pops and compares on every
// write pulse. Status outputs are checked at fixed offsets from the last
// accepted byte. Define LOADER_CHECKSUM_EN to exercise the checksum build.
module tb_instruction_ram_loader;
    import instruction_ram_loader_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clock  = 1'b0;
    logic resetN = 1'b0;
    logic start  = 1'b0;
    logic cpuHold;
    logic done;
    logic error;

    wr_t        exp_q[$];
    logic [7:0] image_q[$];
    int         checks = 0;
    int         errors = 0;

    instruction_ram_loader_if bus_if ();

    instruction_ram_loader dut (
        .clock   (clock),
        .resetN  (resetN),
        .start   (start),
        .bus     (bus_if),
        .cpuHold (cpuHold),
        .done    (done),
        .error   (error)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    // Hard stop in case something stalls beyond any sensible run time.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: each write pulse must match the oldest expected write.
    always @(negedge clock) begin
        wr_t e;
        if (resetN && (bus_if.wrEnable === 1'b1)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got write addr 0x%0h data 0x%0h, expected none",
                         bus_if.wrAddress, bus_if.wrData);
            end else begin
                e = exp_q.pop_front();
                checkOutput("wr_address", 32'(bus_if.wrAddress), e.addr);
                checkOutput("wr_data", bus_if.wrData, e.data);
            end
        end
    end

    function automatic logic [7:0] sum8();
        logic [7:0] s = 8'd0;
        foreach (image_q[i]) s = s + image_q[i];
        return s;
    endfunction

    task automatic pushWord(input logic [31:0] w);
        image_q.push_back(w[31:24]);
        image_q.push_back(w[23:16]);
        image_q.push_back(w[15:8]);
        image_q.push_back(w[7:0]);
    endtask

    task automatic randomImage(input int words);
        image_q.delete();
        for (int i = 0; i < words * 4; i++) image_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Offers one byte and waits (bounded) for the handshake edge.
    task automatic sendByte(input logic [7:0] b, input bit gaps, input bit pulse_start);
        int wait_cnt;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clock);
                bus_if.byteValid = 1'b0;
                start = 1'b0;
            end
        end
        @(negedge clock);
        bus_if.byteIn    = b;
        bus_if.byteValid = 1'b1;
        start            = pulse_start;
        wait_cnt         = 0;
        while ((bus_if.byteReady !== 1'b1) && (wait_cnt < 20)) begin
            @(negedge clock);
            wait_cnt++;
        end
        if (bus_if.byteReady !== 1'b1) checkOutput("byte_ready_timeout", 32'(bus_if.byteReady), 32'd1);
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // Runs a full load of image_q with the given header count and checks the
    // outcome predicted from the count, the data and the checksum byte.
    task automatic applyStimulus(input logic [15:0] count, input bit gaps, input int mid_start,
                                 input logic [7:0] chk);
        logic [31:0] w;
        $display("[TB] load: count=%0d gaps=%0d checksum byte 0x%02h", count, gaps, chk);
        @(negedge clock);
        start            = 1'b1;
        bus_if.byteValid = 1'b0;
        @(negedge clock);
        start = 1'b0;
        checkOutput("start_clears_done", 32'(done), 32'd0);
        checkOutput("start_clears_error", 32'(error), 32'd0);
        checkOutput("start_holds_cpu", 32'(cpuHold), 32'd1);
        checkOutput("start_ready", 32'(bus_if.byteReady), 32'd1);
        sendByte(count[15:8], gaps, 1'b0);
        sendByte(count[7:0], gaps, 1'b0);
        if ((count == 16'd0) || (count > 16'(INSTR_DEPTH))) begin
            @(negedge clock);
            bus_if.byteValid = 1'b0;
            checkOutput("bad_count_error", 32'(error), 32'd1);
            checkOutput("bad_count_done", 32'(done), 32'd0);
            checkOutput("bad_count_hold", 32'(cpuHold), 32'd1);
            checkOutput("bad_count_ready", 32'(bus_if.byteReady), 32'd0);
            repeat (4) @(negedge clock);
            checkOutput("bad_count_error_sticky", 32'(error), 32'd1);
            return;
        end
        for (int i = 0; i < 32'(count) * 4; i++) begin
            if ((i % 4) == 3) begin
                w = {image_q[i-3], image_q[i-2], image_q[i-1], image_q[i]};
                exp_q.push_back('{addr: 32'(i / 4), data: w});
            end
            sendByte(image_q[i], gaps, (i == mid_start));
        end
`ifdef LOADER_CHECKSUM_EN
        sendByte(chk, gaps, 1'b0);
        @(negedge clock);
        bus_if.byteValid = 1'b0;
        if (chk == sum8()) begin
            checkOutput("chk_ok_done", 32'(done), 32'd1);
            checkOutput("chk_ok_hold", 32'(cpuHold), 32'd0);
            checkOutput("chk_ok_error", 32'(error), 32'd0);
        end else begin
            checkOutput("chk_bad_error", 32'(error), 32'd1);
            checkOutput("chk_bad_done", 32'(done), 32'd0);
            checkOutput("chk_bad_hold", 32'(cpuHold), 32'd1);
        end
`else
        @(negedge clock);
        bus_if.byteValid = 1'b0;
        checkOutput("done_not_early", 32'(done), 32'd0);
        checkOutput("hold_during_last_write", 32'(cpuHold), 32'd1);
        @(negedge clock);
        checkOutput("load_done", 32'(done), 32'd1);
        checkOutput("load_release_hold", 32'(cpuHold), 32'd0);
        checkOutput("load_no_error", 32'(error), 32'd0);
`endif
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_byte_ready"}, 32'(bus_if.byteReady), 32'd0);
        checkOutput({tag, "_wr_enable"}, 32'(bus_if.wrEnable), 32'd0);
        checkOutput({tag, "_wr_address"}, 32'(bus_if.wrAddress), 32'd0);
        checkOutput({tag, "_wr_data"}, bus_if.wrData, 32'd0);
        checkOutput({tag, "_cpu_hold"}, 32'(cpuHold), 32'd1);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        bus_if.byteIn    = 8'd0;
        bus_if.byteValid = 1'b0;
        repeat (2) @(negedge clock);
        checkResetValues("reset");
        resetN = 1'b1;
        @(negedge clock);
        checkOutput("idle_ready", 32'(bus_if.byteReady), 32'd0);

        // Two-word image from the reference example.
        image_q.delete();
        pushWord(32'h6C000000);
        pushWord(32'h54000051);
        applyStimulus(16'd2, 1'b0, -1, sum8());

        // Illegal word counts: zero and one past the RAM depth.
        image_q.delete();
        applyStimulus(16'd0, 1'b0, -1, 8'd0);
        applyStimulus(16'd126, 1'b0, -1, 8'd0);

        // Full-depth image with random stream gaps.
        randomImage(125);
        applyStimulus(16'd125, 1'b1, -1, sum8());

`ifdef LOADER_CHECKSUM_EN
        image_q.delete();
        pushWord(32'h01020304);
        applyStimulus(16'd1, 1'b0, -1, 8'h0A);
        applyStimulus(16'd1, 1'b0, -1, 8'h0B);
`endif

        // Reset in the middle of the first data word.
        randomImage(1);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        sendByte(8'h00, 1'b0, 1'b0);
        sendByte(8'h01, 1'b0, 1'b0);
        sendByte(image_q[0], 1'b0, 1'b0);
        sendByte(image_q[1], 1'b0, 1'b0);
        @(negedge clock);
        resetN           = 1'b0;
        bus_if.byteValid = 1'b0;
        #1;
        checkResetValues("midload_reset");
        @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
        checkOutput("post_reset_idle_ready", 32'(bus_if.byteReady), 32'd0);
        randomImage(3);
        applyStimulus(16'd3, 1'b1, -1, sum8());

        // start pulsed during DATA, then a new load started from DONE.
        randomImage(3);
        applyStimulus(16'd3, 1'b0, 5, sum8());
        randomImage(2);
        applyStimulus(16'd2, 1'b0, -1, sum8());

        repeat (5) @(negedge clock);
        checkOutput("expected_writes_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_ram_loader.md
# instruction_ram_loader

Boot-time writer for the processor's instruction memory. Accepts a byte stream (length header, big-endian 32-bit instruction words, optional checksum) over a valid/ready interface. Assembles each group of four bytes into a word and writes it to consecutive instruction-RAM addresses from 0. Holds the CPU in stall until the image is complete, so the instruction fetch path reads only a fully loaded program.

## Interface
- `ADDR_WIDTH`, default 10: width of the instruction-RAM write address. Matches the fetch address width.
- `DEPTH`, default 125: number of instruction words the RAM holds. This is the maximum legal word count.
- `clock` input, 1 bit: single clock; all state changes on the rising edge.
- `resetN` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: one-cycle pulse that begins a load. Ignored while a load is in progress.
- `byteIn` input, 8 bits: stream byte.
- `byteValid` input, 1 bit: `byteIn` holds a valid byte.
- `byteReady` output, 1 bit: the loader accepts a byte this cycle.
- `wrEnable` output, 1 bit: one-cycle instruction-RAM write strobe.
- `wrAddress` output, `ADDR_WIDTH` bits: write address.
- `wrData` output, 32 bits: write data.
- `cpuHold` output, 1 bit: CPU stall request.
- `done` output, 1 bit: image loaded successfully. Sticky.
- `error` output, 1 bit: load aborted. Sticky.

## Operation
- A byte is transferred only in a cycle where `byteValid` and `byteReady` are both 1. `byteIn` is ignored at all other times.
- The states and their transitions are:
  - IDLE: `byteReady`=0. On `start` → CNT_HI, which also clears `done`, `error`, the word counter, the address and the checksum.
  - CNT_HI: the accepted byte becomes count[15:8] → CNT_LO.
  - CNT_LO: the accepted byte becomes count[7:0]. Then:
    - count==0 or count>`DEPTH` → ERROR.
    - otherwise → DATA.
  - DATA: byte index 0..3 selects word bits [31:24], [23:16], [15:8], [7:0] (big-endian). On the 4th byte, the word is registered and the write is issued. When the written word is word count−1, the next state is CHECK, or DONE without the feature. Otherwise the index wraps to 0 and the state stays in DATA.
  - CHECK: described under Configuration.
  - DONE: `done`=1 and `cpuHold`=0. Stays here until `start` → CNT_HI.
  - ERROR: `error`=1 and `cpuHold`=1. Stays here until `start` → CNT_HI.
- `byteReady`=1 exactly in CNT_HI, CNT_LO, DATA and CHECK. The stream is never back-pressured inside those states.
- `cpuHold`=1 in every state except DONE.
- `wrAddress` starts at 0 and increments by 1 after each write. It never exceeds count−1, so it never wraps.
- `start` while in CNT_HI, CNT_LO, DATA or CHECK is ignored.
- A `start` in the same cycle as a handshake in IDLE, DONE or ERROR discards that byte, because `byteReady`=0 in those states.

## Timing
- Reset values: state=IDLE, `byteReady`=0, `wrEnable`=0, `wrAddress`=0, `wrData`=0, `cpuHold`=1, `done`=0, `error`=0.
- Write latency: `wrEnable` pulses for one cycle, in the cycle after the 4th byte of a word is accepted. `wrAddress` and `wrData` are valid and stable in that cycle and hold their values afterwards.
- Back-to-back bytes at one per cycle are supported. A new word's byte 0 may be accepted in the same cycle as the previous word's `wrEnable`.
- `done` and the release of `cpuHold` occur in the cycle after the final write pulse. With the checksum feature, they occur in the cycle after the checksum byte is accepted.
- Asserting `resetN` low mid-load forces the reset values immediately. Partially written RAM contents are left as they are, and the next load requires a new `start`.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - An 8-bit running sum, modulo 256, accumulates every DATA byte. The count bytes are excluded.
  - After the last word, the state goes to CHECK, which accepts one byte.
  - Byte equal to the sum → DONE; unequal → ERROR.
  - Words already written stay in RAM either way.
- `LOADER_CHECKSUM_EN` undefined: the CHECK state and the sum register are absent, and the last write goes directly to DONE.

## Structure
- Shared package holds:
  - the state enumeration (IDLE, CNT_HI, CNT_LO, DATA, CHECK, DONE, ERROR);
  - `INSTR_WIDTH`=32;
  - `INSTR_ADDR_WIDTH`=10;
  - `INSTR_DEPTH`=125.

  The instruction RAM and this loader both use the package constants.
- One sub-module, `byte_word_packer`: shifts 4 bytes into a 32-bit word and flags word-complete. The loader FSM, counters and checksum sit in the top module.

## Test plan
- Reset, then `start`, count=0x0002, bytes 6C 00 00 00 54 00 00 51:
  - writes 0x6C000000 at address 0 and 0x54000051 at address 1;
  - `done`=1 and `cpuHold`=0 one cycle after the last `wrEnable`.
- Count=0x0000, and separately count=126 (0x007E): `error`=1 the cycle after CNT_LO, no `wrEnable` ever, `cpuHold` stays 1.
- Count=125 at one byte per cycle with random `byteValid` gaps: exactly 125 writes, addresses 0..124 in order, data matches the stream.
- With `LOADER_CHECKSUM_EN`:
  - count=1, word 01 02 03 04, checksum 0x0A → DONE;
  - same word with checksum 0x0B → ERROR, word still written at address 0.
- `resetN` low after 2 of 4 data bytes: all outputs return to reset values. A subsequent `start` with a full image loads correctly from address 0.
- `start` pulsed mid-DATA is ignored, and the load completes unchanged. `start` in DONE clears `done`, raises `cpuHold` and begins a new load.
